// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundles the decode/execute status fields consumed by the hazard
//   sequencer and the pipeline control strobes it returns.
//
//   Status fields (driven by the pipeline, read by the sequencer):
//     id_rs, id_rt       source register specifiers of the ID instruction
//     id_uses_rs/_rt     ID instruction actually reads that source
//     id_hlt             ID instruction is HLT
//     ex_lw, ex_rd       EX instruction is a load, and its destination
//     mispredict         EX branch resolved against its prediction
//   Control strobes (driven by the sequencer, read by the pipeline):
//     pc_wen, if_id_wen, if_id_flush, id_ex_bubble, halted, state
//
//   master : pipeline side (drives status, observes controls)
//   slave  : hazard_ctrl side (observes status, drives controls)
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int REG_W = 4
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_hlt;
    logic             ex_lw;
    logic [REG_W-1:0] ex_rd;
    logic             mispredict;

    logic             pc_wen;
    logic             if_id_wen;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             halted;
    logic [2:0]       state;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_hlt,
               ex_lw, ex_rd, mispredict,
        input  pc_wen, if_id_wen, if_id_flush, id_ex_bubble, halted, state
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_hlt,
               ex_lw, ex_rd, mispredict,
        output pc_wen, if_id_wen, if_id_flush, id_ex_bubble, halted, state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencer for the IF/ID stage register and the PC register.
//   Detects load-use hazards, branch mispredicts and HLT, and produces the
//   PC write enable plus IF/ID write/flush and ID/EX bubble controls.
//
//   Parameters:
//     STALL_CYC  bubbles inserted per load-use hazard (clamped to 1..7)
//     DRAIN_CYC  cycles after HLT leaves ID before halted asserts (1..7)
//     REG_W      register-specifier width
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   hazard_ctrl_if.slave: ID/EX status in, pipeline controls out
//
//   All controls are combinational from the registered state/count and the
//   current status inputs. While rst is high the controls take the
//   free-running values so the front end keeps fetching from the reset PC.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int STALL_CYC = 1,
    parameter int DRAIN_CYC = 3,
    parameter int REG_W     = 4
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);

    localparam int STALL_N = (STALL_CYC < 1) ? 1 : ((STALL_CYC > 7) ? 7 : STALL_CYC);
    localparam int DRAIN_N = (DRAIN_CYC < 1) ? 1 : ((DRAIN_CYC > 7) ? 7 : DRAIN_CYC);

    // The first stall cycle is spent in RUN, so LDUSE only covers the rest.
    localparam logic [2:0] STALL_INIT = 3'(STALL_N - 1);
    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_N);

    localparam logic [2:0] S_RUN   = 3'd0;
    localparam logic [2:0] S_LDUSE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_HALT  = 3'd3;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       lu;

    logic       pc_wen;
    logic       if_id_wen;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       halted;

    // Load-use hazard: the load in EX writes a register the ID instruction
    // reads. Register 0 is hard-wired so it can never create a dependency.
    always_comb begin
        lu = bus.ex_lw && (bus.ex_rd != REG_ZERO) &&
             ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
              (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));
    end

    // Next-state and control decode. Mispredict outranks everything in the
    // active states because any held or draining instruction is on the wrong
    // path; HALT is only left through reset.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_wen       = 1'b1;
        if_id_wen    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        halted       = 1'b0;

        if (rst) begin
            state_d = S_RUN;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (bus.mispredict) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        cnt_d        = 3'd0;
                    end else if (lu) begin
                        pc_wen       = 1'b0;
                        if_id_wen    = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (STALL_N == 1) begin
                            cnt_d = 3'd0;
                        end else begin
                            state_d = S_LDUSE;
                            cnt_d   = STALL_INIT;
                        end
                    end else if (bus.id_hlt) begin
                        // HLT itself moves on to EX; only the front end freezes.
                        pc_wen    = 1'b0;
                        if_id_wen = 1'b0;
                        state_d   = S_DRAIN;
                        cnt_d     = DRAIN_INIT;
                    end
                end

                S_LDUSE, S_DRAIN: begin
                    if (bus.mispredict) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_d      = S_RUN;
                        cnt_d        = 3'd0;
                    end else begin
                        pc_wen       = 1'b0;
                        if_id_wen    = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (cnt_q == 3'd1) begin
                            state_d = (state_q == S_LDUSE) ? S_RUN : S_HALT;
                            cnt_d   = 3'd0;
                        end else begin
                            cnt_d = 3'(cnt_q - 3'd1);
                        end
                    end
                end

                S_HALT: begin
                    pc_wen    = 1'b0;
                    if_id_wen = 1'b0;
                    halted    = 1'b1;
                end

                default: begin
                    // Unused encodings fall back to RUN rather than lock up.
                    state_d = S_RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // State and stall/drain counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc_wen       = pc_wen;
    assign bus.if_id_wen    = if_id_wen;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.halted       = halted;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Drives two hazard_ctrl instances (STALL_CYC=1 and STALL_CYC=3, both with
//   DRAIN_CYC=3) with identical directed stimulus. Each step pushes the
//   expected control vector for both instances into a scoreboard queue; the
//   entry is popped and compared half a cycle later.
//   Vector layout: {state[2:0], pc_wen, if_id_wen, if_id_flush, bubble, halted}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [2:0] RUN = 3'd0;
    localparam logic [2:0] LDU = 3'd1;
    localparam logic [2:0] DRN = 3'd2;
    localparam logic [2:0] HLT = 3'd3;

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb[$];

    hazard_ctrl_if #(.REG_W(4)) if_a ();
    hazard_ctrl_if #(.REG_W(4)) if_b ();

    hazard_ctrl #(.STALL_CYC(1), .DRAIN_CYC(3), .REG_W(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    hazard_ctrl #(.STALL_CYC(3), .DRAIN_CYC(3), .REG_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ev(input logic [2:0] st, input logic pc, input logic ifw,
                                      input logic fl, input logic bub, input logic h);
        return {st, pc, ifw, fl, bub, h};
    endfunction

    // Drive the same status to both instances and record what each must show.
    task automatic apply_stimulus(input string tag, input logic r,
                                  input logic [3:0] rs, input logic [3:0] rt,
                                  input logic urs, input logic urt, input logic hlt,
                                  input logic lw, input logic [3:0] rd, input logic mp,
                                  input logic [7:0] ea, input logic [7:0] eb);
        exp_t e;
        rst = r;
        if_a.id_rs = rs;  if_b.id_rs = rs;
        if_a.id_rt = rt;  if_b.id_rt = rt;
        if_a.id_uses_rs = urs;  if_b.id_uses_rs = urs;
        if_a.id_uses_rt = urt;  if_b.id_uses_rt = urt;
        if_a.id_hlt = hlt;  if_b.id_hlt = hlt;
        if_a.ex_lw = lw;  if_b.ex_lw = lw;
        if_a.ex_rd = rd;  if_b.ex_rd = rd;
        if_a.mispredict = mp;  if_b.mispredict = mp;
        e.tag = tag;
        e.a   = ea;
        e.b   = eb;
        sb.push_back(e);
    endtask

    task automatic check_output();
        exp_t       e;
        logic [7:0] oa;
        logic [7:0] ob;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
            return;
        end
        e  = sb.pop_front();
        oa = {if_a.state, if_a.pc_wen, if_a.if_id_wen, if_a.if_id_flush, if_a.id_ex_bubble, if_a.halted};
        ob = {if_b.state, if_b.pc_wen, if_b.if_id_wen, if_b.if_id_flush, if_b.id_ex_bubble, if_b.halted};
        compared++;
        assert (oa === e.a) else begin
            mismatched++;
            $error("[TB] FAIL %s/stall1 observed=%b expected=%b", e.tag, oa, e.a);
        end
        compared++;
        assert (ob === e.b) else begin
            mismatched++;
            $error("[TB] FAIL %s/stall3 observed=%b expected=%b", e.tag, ob, e.b);
        end
    endtask

    // One clock step: drive just after a rising edge, check on the falling edge.
    task automatic step(input string tag, input logic r,
                        input logic [3:0] rs, input logic [3:0] rt,
                        input logic urs, input logic urt, input logic hlt,
                        input logic lw, input logic [3:0] rd, input logic mp,
                        input logic [7:0] ea, input logic [7:0] eb);
        apply_stimulus(tag, r, rs, rt, urs, urt, hlt, lw, rd, mp, ea, eb);
        @(negedge clk);
        check_output();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] nrm;
        logic [7:0] stl_run;
        logic [7:0] stl_ldu;
        logic [7:0] flush_run;
        logic [7:0] hold;
        logic [7:0] drn;
        logic [7:0] hlt_st;

        nrm       = ev(RUN, 1, 1, 0, 0, 0);
        stl_run   = ev(RUN, 0, 0, 0, 1, 0);
        stl_ldu   = ev(LDU, 0, 0, 0, 1, 0);
        flush_run = ev(RUN, 1, 1, 1, 1, 0);
        hold      = ev(RUN, 0, 0, 0, 0, 0);
        drn       = ev(DRN, 0, 0, 0, 1, 0);
        hlt_st    = ev(HLT, 0, 0, 0, 0, 1);

        apply_stimulus("init", 1, 0, 0, 0, 0, 0, 0, 0, 0, nrm, nrm);
        void'(sb.pop_back());
        @(posedge clk);
        #1;

        //    tag              rst rs rt urs urt hlt lw rd mp   dut_a      dut_b
        step("reset",           1, 0, 0, 0, 0, 0, 0, 0, 0, nrm,       nrm);
        step("idle",            0, 0, 0, 0, 0, 0, 0, 0, 0, nrm,       nrm);

        step("lu_rs",           0, 5, 0, 1, 0, 0, 1, 5, 0, stl_run,   stl_run);
        step("lu_rs_c1",        0, 0, 0, 0, 0, 0, 0, 0, 0, nrm,       stl_ldu);
        step("lu_rs_c2",        0, 0, 0, 0, 0, 0, 0, 0, 0, nrm,       stl_ldu);
        step("lu_rs_done",      0, 0, 0, 0, 0, 0, 0, 0, 0, nrm,       nrm);

        step("rd_zero",         0, 0, 0, 1, 0, 0, 1, 0, 0, nrm,       nrm);
        step("rt_unused",       0, 0, 7, 0, 0, 0, 1, 7, 0, nrm,       nrm);
        step("lu_rt",           0, 0, 7, 0, 1, 0, 1, 7, 0, stl_run,   stl_run);
        step("lu_back2back",    0, 0, 7, 0, 1, 0, 1, 7, 0, stl_run,   stl_ldu);
        step("b2b_c1",          0, 0, 0, 0, 0, 0, 0, 0, 0, nrm,       stl_ldu);
        step("b2b_done",        0, 0, 0, 0, 0, 0, 0, 0, 0, nrm,       nrm);

        step("mp_with_lu",      0, 5, 0, 1, 0, 0, 1, 5, 1, flush_run, flush_run);
        step("mp_with_lu_next", 0, 0, 0, 0, 0, 0, 0, 0, 0, nrm,       nrm);
        step("lu_before_mp",    0, 5, 0, 1, 0, 0, 1, 5, 0, stl_run,   stl_run);
        step("mp_in_ldUSE",     0, 0, 0, 0, 0, 0, 0, 0, 1, flush_run, ev(LDU, 1, 1, 1, 1, 0));
        step("mp_ldu_next",     0, 0, 0, 0, 0, 0, 0, 0, 0, nrm,       nrm);

        step("lu_over_hlt",     0, 5, 0, 1, 0, 1, 1, 5, 0, stl_run,   stl_run);
        step("lu_hlt_c1",       0, 0, 0, 0, 0, 0, 0, 0, 0, nrm,       stl_ldu);
        step("lu_hlt_c2",       0, 0, 0, 0, 0, 0, 0, 0, 0, nrm,       stl_ldu);
        step("lu_hlt_done",     0, 0, 0, 0, 0, 0, 0, 0, 0, nrm,       nrm);

        step("hlt_t6",          0, 0, 0, 0, 0, 1, 0, 0, 0, hold,      hold);
        step("drain1_t6",       0, 0, 0, 0, 0, 1, 0, 0, 0, drn,       drn);
        step("drain2_mp",       0, 0, 0, 0, 0, 1, 0, 0, 1, ev(DRN, 1, 1, 1, 1, 0), ev(DRN, 1, 1, 1, 1, 0));
        step("after_drain_mp",  0, 0, 0, 0, 0, 0, 0, 0, 0, nrm,       nrm);

        step("hlt_t1",          0, 0, 0, 0, 0, 1, 0, 0, 0, hold,      hold);
        step("drain1_t1",       0, 0, 0, 0, 0, 1, 0, 0, 0, drn,       drn);
        step("rst_mid_drain",   1, 0, 0, 0, 0, 1, 0, 0, 0, ev(DRN, 1, 1, 0, 0, 0), ev(DRN, 1, 1, 0, 0, 0));
        step("rst_held",        1, 0, 0, 0, 0, 1, 0, 0, 0, nrm,       nrm);
        step("post_rst",        0, 0, 0, 0, 0, 0, 0, 0, 0, nrm,       nrm);

        step("hlt_t5",          0, 0, 0, 0, 0, 1, 0, 0, 0, hold,      hold);
        step("drain1_t5",       0, 0, 0, 0, 0, 1, 0, 0, 0, drn,       drn);
        step("drain2_t5",       0, 0, 0, 0, 0, 1, 0, 0, 0, drn,       drn);
        step("drain3_t5",       0, 0, 0, 0, 0, 1, 0, 0, 0, drn,       drn);
        step("halt_ign_mp_lu",  0, 5, 0, 1, 0, 0, 1, 5, 1, hlt_st,    hlt_st);
        step("halt_idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, hlt_st,    hlt_st);
        step("halt_hlt",        0, 0, 0, 0, 0, 1, 0, 0, 0, hlt_st,    hlt_st);

        step("rst_in_halt",     1, 0, 0, 0, 0, 0, 0, 0, 0, ev(HLT, 1, 1, 0, 0, 0), ev(HLT, 1, 1, 0, 0, 0));
        step("after_halt_rst",  0, 0, 0, 0, 0, 0, 0, 0, 0, nrm,       nrm);

        compared++;
        assert (sb.size() === 0) else begin
            mismatched++;
            $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
